// File: rtl/ts4231_cfg_responder.sv
// ts4231_cfg_responder
//
// Emulates the configuration side of a TS4231 light-to-digital converter on
// its two-wire E/D bus. The host frames a transaction with a start condition
// (D falls while E is high), sends one R/W bit and then either writes 16 data
// bits or clocks 16 configuration bits back out of the responder. A stop
// condition (D rises while E is high) ends the frame.
//
// Write frame: start, RW=1, 16 bits MSB first (sampled on E rising), stop.
//   cfg_q is updated and cfg_wr pulses in the cycle the stop is detected.
// Read frame:  start, RW=0, then on each E falling edge the responder drives
//   the next cfg_q bit MSB first; on the E falling edge after bit 15 it
//   releases D and pulses rd_done. The host then issues a stop.
// A stop arriving before a frame is complete, or a start arriving inside a
// frame, aborts it with a frame_err pulse.
//
// Optional feature macro: TS4231_CFG_RESPONDER_READBACK_EN
//   defined   -> read frames drive cfg_q back onto D as described above.
//   undefined -> a read frame is accepted but ignored: d_oe stays 0, rd_done
//                stays 0, and the closing stop returns to IDLE silently.
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency (documentation / bench timing only)
//   CFG_RESET    reset value of the configuration register
//   SYNC_STAGES  synchronizer depth for e_i/d_i, 2..4
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   e_i        in   E line at the pad (pulled high when undriven)
//   d_i        in   D line at the pad (pulled high when undriven)
//   d_o        out  value driven onto D during read-back
//   d_oe       out  D output enable, 1 = responder drives D
//   cfg_q      out  current 16-bit configuration word
//   cfg_wr     out  one-cycle pulse when a write frame updates cfg_q
//   rd_done    out  one-cycle pulse when a read frame completes
//   frame_err  out  one-cycle pulse when a frame is aborted
//   busy       out  high whenever the FSM is outside IDLE
//   dbg_state  out  raw FSM state for observation
//
// Pad-edge to reaction latency is SYNC_STAGES+1 clk cycles, so every E
// half-period at the pad has to last longer than SYNC_STAGES+2 clk cycles.

module ts4231_cfg_responder #(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter logic [15:0] CFG_RESET   = 16'h0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_i,
    input  logic        d_i,
    output logic        d_o,
    output logic        d_oe,
    output logic [15:0] cfg_q,
    output logic        cfg_wr,
    output logic        rd_done,
    output logic        frame_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    if (CLK_FREQ_HZ < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_param_check
        $error("ts4231_cfg_responder: illegal CLK_FREQ_HZ or SYNC_STAGES");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RW        = 3'd1,
        S_WDATA     = 3'd2,
        S_RDATA     = 3'd3,
        S_WAIT_STOP = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Reset to 1 to match the idle (pulled-up) bus so
    // leaving reset never manufactures a start or stop condition.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] e_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic                   es_d;
    logic                   ds_d;
    logic                   es;
    logic                   ds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_sync <= '1;
            d_sync <= '1;
            es_d   <= 1'b1;
            ds_d   <= 1'b1;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], e_i};
            d_sync <= {d_sync[SYNC_STAGES-2:0], d_i};
            es_d   <= es;
            ds_d   <= ds;
        end
    end

    assign es = e_sync[SYNC_STAGES-1];
    assign ds = d_sync[SYNC_STAGES-1];

    logic es_rise;
    logic es_fall;
    logic start_c;
    logic stop_c;

    assign es_rise = es & ~es_d;
    assign es_fall = ~es & es_d;
    // While we drive D the synchronized D reflects our own data, so bus
    // conditions are only recognised when D is released.
    assign start_c = es & ds_d & ~ds & ~d_oe;
    assign stop_c  = es & ~ds_d & ds & ~d_oe;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;          // bits shifted in / driven out so far
    logic [15:0] shreg, shreg_n;
    logic [15:0] cfg_n;
    logic        is_wr, is_wr_n;      // frame direction latched from RW bit
    logic        d_o_n, d_oe_n;
    logic        cfg_wr_n, rd_done_n, frame_err_n;
    logic        pulse_prev;

    // Guarantees no two status pulses in consecutive cycles, e.g. a
    // repeated start right after a completed read.
    assign pulse_prev = cfg_wr | rd_done | frame_err;

`ifdef TS4231_CFG_RESPONDER_READBACK_EN
    logic [3:0] bit_idx;
    assign bit_idx = 4'd15 - cnt[3:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            cfg_q     <= CFG_RESET;
            is_wr     <= 1'b0;
            d_o       <= 1'b0;
            d_oe      <= 1'b0;
            cfg_wr    <= 1'b0;
            rd_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            cfg_q     <= cfg_n;
            is_wr     <= is_wr_n;
            d_o       <= d_o_n;
            d_oe      <= d_oe_n;
            cfg_wr    <= cfg_wr_n;
            rd_done   <= rd_done_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        cfg_n       = cfg_q;
        is_wr_n     = is_wr;
        d_o_n       = d_o;
        d_oe_n      = d_oe;
        cfg_wr_n    = 1'b0;
        rd_done_n   = 1'b0;
        frame_err_n = 1'b0;

        if (start_c && (state != S_IDLE)) begin
            // Repeated start: abandon the current frame and begin a new one.
            frame_err_n = ~pulse_prev;
            state_n     = S_RW;
            cnt_n       = '0;
            shreg_n     = '0;
            d_oe_n      = 1'b0;
            d_o_n       = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        state_n = S_RW;
                        cnt_n   = '0;
                        shreg_n = '0;
                    end
                end

                S_RW: begin
                    if (stop_c) begin
                        frame_err_n = ~pulse_prev;
                        state_n     = S_IDLE;
                    end else if (es_rise) begin
                        is_wr_n = ds;
                        if (ds) begin
                            state_n = S_WDATA;
                        end else begin
`ifdef TS4231_CFG_RESPONDER_READBACK_EN
                            state_n = S_RDATA;
`else
                            state_n = S_WAIT_STOP;
`endif
                        end
                    end
                end

                S_WDATA: begin
                    if (stop_c) begin
                        frame_err_n = ~pulse_prev;
                        state_n     = S_IDLE;
                    end else if (es_rise) begin
                        shreg_n = {shreg[14:0], ds};
                        cnt_n   = cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            state_n = S_WAIT_STOP;
                        end
                    end
                end

                S_RDATA: begin
`ifdef TS4231_CFG_RESPONDER_READBACK_EN
                    // A stop can only be seen here before the first bit is
                    // driven (afterwards d_oe masks it); it is still an abort.
                    if (stop_c) begin
                        frame_err_n = ~pulse_prev;
                        state_n     = S_IDLE;
                    end else if (es_fall) begin
                        if (cnt == 5'd16) begin
                            d_oe_n    = 1'b0;
                            d_o_n     = 1'b0;
                            rd_done_n = 1'b1;
                            state_n   = S_WAIT_STOP;
                        end else begin
                            d_oe_n = 1'b1;
                            d_o_n  = cfg_q[bit_idx];
                            cnt_n  = cnt + 5'd1;
                        end
                    end
`else
                    state_n = S_IDLE;
`endif
                end

                S_WAIT_STOP: begin
                    // E edges are ignored here; only the stop matters.
                    if (stop_c) begin
                        if (is_wr) begin
                            cfg_n    = shreg;
                            cfg_wr_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ts4231_cfg_responder.sv
// Bench for ts4231_cfg_responder: a host model drives E/D frames, a small
// frame-level model tracks the configuration word, and read-back bits are
// compared against an expected queue.

module tb_ts4231_cfg_responder;

    localparam logic [15:0] CFG_RST = 16'hA5C3;
    localparam int          H       = 8;   // clk cycles per host bus step
`ifdef TS4231_CFG_RESPONDER_READBACK_EN
    localparam logic        RB      = 1'b1;
`else
    localparam logic        RB      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_e = 1'b1;
    logic        host_d = 1'b1;
    logic        e_line;
    logic        d_line;
    logic        d_o;
    logic        d_oe;
    logic [15:0] cfg_q;
    logic        cfg_wr;
    logic        rd_done;
    logic        frame_err;
    logic        busy;
    logic [2:0]  dbg_state;

    // Shared D wire: responder wins while it drives, otherwise the host.
    assign e_line = host_e;
    assign d_line = d_oe ? d_o : host_d;

    ts4231_cfg_responder #(
        .CLK_FREQ_HZ (50_000_000),
        .CFG_RESET   (CFG_RST),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .e_i       (e_line),
        .d_i       (d_line),
        .d_o       (d_o),
        .d_oe      (d_oe),
        .cfg_q     (cfg_q),
        .cfg_wr    (cfg_wr),
        .rd_done   (rd_done),
        .frame_err (frame_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_err  = 0;
    logic prev_pulse = 1'b0;

    logic [15:0] model_cfg;
    logic [0:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Pulse monitor: counts status pulses and checks exclusivity / spacing.
    always @(negedge clk) begin
        if (reset) begin
            prev_pulse = 1'b0;
        end else begin
            if (cfg_wr | rd_done | frame_err) begin
                check("pulse_onehot", 32'($countones({cfg_wr, rd_done, frame_err})), 1);
                check("pulse_gap", {31'd0, prev_pulse}, 0);
            end
            prev_pulse = cfg_wr | rd_done | frame_err;
            n_wr  += int'(cfg_wr);
            n_rd  += int'(rd_done);
            n_err += int'(frame_err);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- host driver tasks ----------------
    task automatic step();
        repeat (H) @(negedge clk);
    endtask

    // Works from idle or mid-frame: D only changes while E is low, then D
    // falls with E high.
    task automatic send_start();
        host_e = 1'b0; step();
        host_d = 1'b1; step();
        host_e = 1'b1; step();
        host_d = 1'b0; step();
    endtask

    task automatic send_bit(input logic b);
        host_e = 1'b0; step();
        host_d = b;    step();
        host_e = 1'b1; step();
    endtask

    task automatic send_stop();
        host_e = 1'b0; step();
        host_d = 1'b0; step();
        host_e = 1'b1; step();
        host_d = 1'b1; step();
    endtask

    // nbits==16 is a complete write; nbits<=14 is a truncated one. The stop
    // sequence adds one more E rise, so a truncated frame still stays short.
    task automatic do_write(input logic [15:0] v, input int nbits);
        int w0, e0, r0;
        w0 = n_wr; e0 = n_err; r0 = n_rd;
        send_start();
        check("wr_busy", {31'd0, busy}, 1);
        send_bit(1'b1);
        for (int i = 0; i < nbits; i++) send_bit(v[15-i]);
        send_stop();
        step();
        if (nbits == 16) model_cfg = v;
        check("wr_pulse", n_wr - w0, (nbits == 16) ? 1 : 0);
        check("wr_err", n_err - e0, (nbits == 16) ? 0 : 1);
        check("wr_rd", n_rd - r0, 0);
        check("wr_cfg", cfg_q, model_cfg);
        check("wr_idle", {31'd0, busy}, 0);
    endtask

    task automatic do_read();
        logic b;
        int w0, e0, r0;
        w0 = n_wr; e0 = n_err; r0 = n_rd;
        send_start();
        check("rd_busy", {31'd0, busy}, 1);
        send_bit(1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(RB ? model_cfg[15-i] : 1'b0);
        for (int i = 0; i < 16; i++) begin
            host_e = 1'b0; step();
            check("rd_oe", {31'd0, d_oe}, {31'd0, RB});
            b = d_line;   // value the host sees as E rises
            check("rd_bit", {31'd0, b}, {31'd0, exp_q.pop_front()});
            host_e = 1'b1; step();
        end
        host_e = 1'b0; step();
        check("rd_release", {31'd0, d_oe}, 0);
        send_stop();
        step();
        check("rd_done_cnt", n_rd - r0, RB ? 1 : 0);
        check("rd_err", n_err - e0, 0);
        check("rd_wr", n_wr - w0, 0);
        check("rd_cfg", cfg_q, model_cfg);
        check("rd_idle", {31'd0, busy}, 0);
    endtask

    // Partial write, repeated start, then a complete write of v.
    task automatic do_restart(input int nbits, input logic [15:0] v);
        int w0, e0;
        w0 = n_wr; e0 = n_err;
        send_start();
        send_bit(1'b1);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        send_start();
        step();
        check("rs_err", n_err - e0, 1);
        check("rs_cfg_kept", cfg_q, model_cfg);
        check("rs_busy", {31'd0, busy}, 1);
        send_bit(1'b1);
        for (int i = 0; i < 16; i++) send_bit(v[15-i]);
        send_stop();
        step();
        model_cfg = v;
        check("rs_wr", n_wr - w0, 1);
        check("rs_err_total", n_err - e0, 1);
        check("rs_cfg", cfg_q, model_cfg);
    endtask

    // Reset while bit 5 of a read frame is on the bus.
    task automatic do_reset_mid_read();
        int e0, r0;
        e0 = n_err; r0 = n_rd;
        send_start();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            host_e = 1'b0; step();
            host_e = 1'b1; step();
        end
        host_e = 1'b0; step();
        check("rst_pre_oe", {31'd0, d_oe}, {31'd0, RB});
        #3 reset = 1'b1;
        #1;
        check("rst_oe_async", {31'd0, d_oe}, 0);
        check("rst_cfg", cfg_q, CFG_RST);
        check("rst_busy", {31'd0, busy}, 0);
        host_e = 1'b1;
        host_d = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_err", n_err - e0, 0);
        check("rst_no_rd", n_rd - r0, 0);
        reset = 1'b0;
        model_cfg = CFG_RST;
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_cfg = CFG_RST;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_cfg", cfg_q, CFG_RST);
        check("reset_oe", {31'd0, d_oe}, 0);
        check("reset_do", {31'd0, d_o}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_pulses", {29'd0, cfg_wr, rd_done, frame_err}, 0);
        reset = 1'b0;
        step();
        check("idle_busy", {31'd0, busy}, 0);

        do_write(16'h392B, 16);
        do_read();
        do_write(16'hFFFF, 7);
        check("short_cfg", cfg_q, 16'h392B);
        do_restart(9, 16'h00FF);
        check("restart_cfg", cfg_q, 16'h00FF);
        do_reset_mid_read();
        do_write(16'h8001, 16);
        do_write(16'h0000, 0);
        do_read();

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: do_write(16'($urandom), 16);
                1: do_write(16'($urandom), $urandom_range(0, 14));
                2: do_read();
                default: do_restart($urandom_range(0, 15), 16'($urandom));
            endcase
        end
        do_read();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
